food_placer: RTL and testbench

// - Consumes the free-running 10-bit X/Y pseudo-random words from the LFSR stage. Turns them into a legal food cell on the snake grid.
// - Rejects cells occupied by the snake by querying the body-occupancy store. Falls back to a deterministic raster scan after MAX_TRIES rejections.
// - Sits between the LFSR and the game controller / renderer, which read food_x/food_y.

---
 rtl/snake_pkg.sv | 18 +
 rtl/coord_mapper.sv | 21 ++
 rtl/food_placer.sv | 166 ++++++++++++++++
 tb/tb_food_placer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game datapath and the food_placer state encoding.
package snake_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int XW_C   = 6;
    localparam int YW_C   = 5;
    localparam int LFSR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_SCAN_ISSUE = 3'd3,
        ST_SCAN_WAIT  = 3'd4
    } fp_state_e;

endpackage

// File: rtl/coord_mapper.sv
// Folds a raw random word into [0, LIMIT) with one conditional subtract.
// Only valid while 2**W < 2*LIMIT, so a single subtract always lands in range.
module coord_mapper #(
    parameter int W     = 6,
    parameter int LIMIT = 40
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] mapped
);

    localparam logic [W-1:0] LIM_C = W'(LIMIT);

    // Subtract the grid size once when the raw value overshoots it
    always_comb begin
        mapped = raw;
        if (raw >= LIM_C) begin
            mapped = raw - LIM_C;
        end
    end

endmodule

// File: rtl/food_placer.sv
// Picks a free grid cell for the food: random draws checked against the snake
// body store, then a raster scan from (0,0) once the random attempts run out.
module food_placer
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              place_req,
    input  logic [LFSR_W-1:0] lfsr_x,
    input  logic [LFSR_W-1:0] lfsr_y,
    output logic              occ_req,
    output logic [XW_C-1:0]   occ_x,
    output logic [YW_C-1:0]   occ_y,
    input  logic              occ_hit,
    output logic [XW_C-1:0]   food_x,
    output logic [YW_C-1:0]   food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    localparam int              TW     = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]   MAX_T  = TW'(MAX_TRIES);
    localparam logic [XW_C-1:0] X_LAST = XW_C'(GRID_W - 1);
    localparam logic [YW_C-1:0] Y_LAST = YW_C'(GRID_H - 1);

    fp_state_e       state_q, state_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic [XW_C-1:0] cand_x_q, cand_x_d;
    logic [YW_C-1:0] cand_y_q, cand_y_d;
    logic [XW_C-1:0] food_x_q, food_x_d;
    logic [YW_C-1:0] food_y_q, food_y_d;
    logic            food_valid_q, food_valid_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;

    logic [XW_C-1:0] draw_x;
    logic [YW_C-1:0] draw_y;

    // Upper LFSR bits carry no information for the grid mapping
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^{lfsr_x[LFSR_W-1:XW_C], lfsr_y[LFSR_W-1:YW_C]};

    coord_mapper #(.W(XW_C), .LIMIT(GRID_W)) u_map_x (
        .raw    (lfsr_x[XW_C-1:0]),
        .mapped (draw_x)
    );

    coord_mapper #(.W(YW_C), .LIMIT(GRID_H)) u_map_y (
        .raw    (lfsr_y[YW_C-1:0]),
        .mapped (draw_y)
    );

    // Next-state logic: draw / query / accept / scan; done and fail are single-cycle pulses
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (place_req) begin
                    cand_x_d     = draw_x;
                    cand_y_d     = draw_y;
                    tries_d      = TW'(1);
                    food_valid_d = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!occ_hit) begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else if (tries_q < MAX_T) begin
                    cand_x_d = draw_x;
                    cand_y_d = draw_y;
                    tries_d  = tries_q + 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    // Random attempts exhausted: walk the grid deterministically
                    cand_x_d = '0;
                    cand_y_d = '0;
                    state_d  = ST_SCAN_ISSUE;
                end
            end
            ST_SCAN_ISSUE: begin
                state_d = ST_SCAN_WAIT;
            end
            ST_SCAN_WAIT: begin
                if (!occ_hit) begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else if (cand_x_q == X_LAST && cand_y_q == Y_LAST) begin
                    // Last cell of the raster also occupied: the board is full
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (cand_x_q == X_LAST) begin
                        cand_x_d = '0;
                        cand_y_d = cand_y_q + 1'b1;
                    end else begin
                        cand_x_d = cand_x_q + 1'b1;
                    end
                    state_d = ST_SCAN_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, candidate and food registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tries_q      <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign occ_req    = (state_q == ST_ISSUE) || (state_q == ST_SCAN_ISSUE);
    assign occ_x      = cand_x_q;
    assign occ_y      = cand_y_q;
    assign busy       = (state_q != ST_IDLE);
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign done       = done_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: per-cycle comparison against a transaction-level model
// that predicts the full query sequence and outcome of each placement.
module tb_food_placer;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int MT = 64;
    localparam int TN = 16384;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       place_req;
    logic [9:0] lfsr_x, lfsr_y;
    logic       occ_req;
    logic [5:0] occ_x;
    logic [4:0] occ_y;
    logic       occ_hit;
    logic [5:0] food_x;
    logic [4:0] food_y;
    logic       food_valid, busy, done, fail;

    food_placer #(.MAX_TRIES(MT)) dut (
        .clk(clk), .rst_n(rst_n), .place_req(place_req),
        .lfsr_x(lfsr_x), .lfsr_y(lfsr_y),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    // cycle c = interval after posedge number c
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int mis = 0;
    int dn  = 0;

    bit occ_map [0:63][0:31];
    int tab_x [0:TN-1];
    int tab_y [0:TN-1];

    // model of the current placement
    bit txn_act = 1'b0;
    bit txn_ok;
    int txn_e, txn_end, txn_fx, txn_fy, nq;
    int qx [0:1299];
    int qy [0:1299];
    int exp_fx = 0;
    int exp_fy = 0;
    bit exp_fv = 1'b0;

    function automatic int mx(int v); return (v % 64) % GW; endfunction
    function automatic int my(int v); return (v % 32) % GH; endfunction

    // occupancy store: answers exactly one cycle after a query, noise otherwise
    initial begin : occ_store
        bit pend;
        int px, py;
        occ_hit = 1'b0;
        forever begin
            @(negedge clk);
            pend = occ_req;
            px = occ_x;
            py = occ_y;
            @(posedge clk);
            #1;
            occ_hit = pend ? occ_map[px][py] : 1'($urandom);
        end
    end

    task automatic chk(string nm, int act, int exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Predict the whole placement started by place_req sampled at edge e
    task automatic start_txn(int e);
        int x, y, ed;
        txn_act = 1'b1;
        txn_e   = e;
        txn_ok  = 1'b0;
        nq      = 0;
        for (int k = 0; k < MT && !txn_ok; k++) begin
            ed = e + 2 * k;
            x  = mx(tab_x[ed % TN]);
            y  = my(tab_y[ed % TN]);
            qx[nq] = x; qy[nq] = y; nq++;
            if (!occ_map[x][y]) begin txn_ok = 1'b1; txn_fx = x; txn_fy = y; end
        end
        for (int j = 0; j < GW * GH && !txn_ok; j++) begin
            x = j % GW;
            y = j / GW;
            qx[nq] = x; qy[nq] = y; nq++;
            if (!occ_map[x][y]) begin txn_ok = 1'b1; txn_fx = x; txn_fy = y; end
        end
        txn_end = e + 2 * (nq - 1) + 2;
    endtask

    task automatic compare();
        bit eb, er, ed, ef;
        int k;
        if (txn_act && cyc == txn_e) exp_fv = 1'b0;
        if (txn_act && cyc == txn_end && txn_ok) begin
            exp_fx = txn_fx; exp_fy = txn_fy; exp_fv = 1'b1;
        end
        eb = txn_act && cyc >= txn_e && cyc < txn_end;
        er = eb && ((cyc - txn_e) % 2 == 0);
        k  = (cyc - txn_e) / 2;
        ed = txn_act && cyc == txn_end && txn_ok;
        ef = txn_act && cyc == txn_end && !txn_ok;
        chk("busy", busy, eb);
        chk("occ_req", occ_req, er);
        if (er) begin
            chk("occ_x", occ_x, qx[k]);
            chk("occ_y", occ_y, qy[k]);
        end
        chk("done", done, ed);
        chk("fail", fail, ef);
        chk("food_valid", food_valid, exp_fv);
        chk("food_x", food_x, exp_fx);
        chk("food_y", food_y, exp_fy);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (done === 1'b1) dn++;
        lfsr_x = 10'(tab_x[(cyc + 1) % TN]);
        lfsr_y = 10'(tab_y[(cyc + 1) % TN]);
    endtask

    task automatic wait_until(int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle();
        if (txn_act) wait_until(txn_end + 1);
    endtask

    task automatic place();
        place_req = 1'b1;
        if (!txn_act || cyc >= txn_end) start_txn(cyc + 1);
        tick();
        place_req = 1'b0;
    endtask

    task automatic set_draw(int ed, int x, int y);
        tab_x[ed % TN] = x | (int'($urandom_range(0, 15)) << 6);
        tab_y[ed % TN] = y | (int'($urandom_range(0, 31)) << 5);
        if (ed == cyc + 1) begin
            lfsr_x = 10'(tab_x[ed % TN]);
            lfsr_y = 10'(tab_y[ed % TN]);
        end
    endtask

    task automatic fill_map(int pct);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                occ_map[x][y] = ($urandom_range(0, 99) < pct);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int c0;
        rst_n     = 1'b0;
        place_req = 1'b0;
        for (int i = 0; i < TN; i++) begin
            tab_x[i] = int'($urandom_range(0, 1023));
            tab_y[i] = int'($urandom_range(0, 1023));
            // keep random draws off (7,3) so the scan fallback can be forced to find it
            if (mx(tab_x[i]) == 7 && my(tab_y[i]) == 3) tab_y[i] = tab_y[i] ^ 1;
        end
        lfsr_x = 10'(tab_x[1]);
        lfsr_y = 10'(tab_y[1]);
        fill_map(0);

        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_occ_req", occ_req, 0);
        chk("reset_food_valid", food_valid, 0);
        chk("reset_food_x", food_x, 0);
        chk("reset_occ_x", occ_x, 0);
        rst_n = 1'b1;
        tick(); tick();

        // free board, draw (12,7): query next cycle, done two cycles later
        c0 = cyc;
        set_draw(c0 + 1, 12, 7);
        place();
        chk("t1_occ_req", occ_req, 1);
        chk("t1_occ_x", occ_x, 12);
        chk("t1_occ_y", occ_y, 7);
        wait_until(c0 + 3);
        chk("t1_done", done, 1);
        chk("t1_food_x", food_x, 12);
        chk("t1_food_y", food_y, 7);
        chk("t1_food_valid", food_valid, 1);
        wait_idle(); tick();

        // wrap in the mapping: low bits 45 / 31 -> (5,1)
        c0 = cyc;
        set_draw(c0 + 1, 45, 31);
        place();
        wait_until(c0 + 3);
        chk("t2_done", done, 1);
        chk("t2_food_x", food_x, 5);
        chk("t2_food_y", food_y, 1);
        wait_idle(); tick();

        // first three draws occupied, fourth free
        occ_map[1][1] = 1'b1; occ_map[2][2] = 1'b1; occ_map[3][3] = 1'b1;
        c0 = cyc;
        set_draw(c0 + 1, 1, 1);
        set_draw(c0 + 3, 2, 2);
        set_draw(c0 + 5, 3, 3);
        set_draw(c0 + 7, 4, 4);
        place();
        wait_until(c0 + 8);
        chk("t3_done_early", done, 0);
        tick();
        chk("t3_done", done, 1);
        chk("t3_food_x", food_x, 4);
        chk("t3_food_y", food_y, 4);
        wait_idle(); tick();

        // only (7,3) free: scan fallback finds it
        fill_map(100);
        occ_map[7][3] = 1'b0;
        c0 = cyc;
        place();
        wait_until(c0 + 1 + 2 * (MT + 3 * GW + 7) + 2);
        chk("t4_done", done, 1);
        chk("t4_food_x", food_x, 7);
        chk("t4_food_y", food_y, 3);
        wait_idle(); tick();

        // board full: fail pulse, no done
        fill_map(100);
        dn = 0;
        c0 = cyc;
        place();
        wait_until(c0 + 1 + 2 * (MT + GW * GH - 1) + 2);
        chk("t5_fail", fail, 1);
        chk("t5_food_valid", food_valid, 0);
        wait_idle(); tick();
        chk("t5_done_count", dn, 0);

        // repeated place_req while busy is ignored
        fill_map(60);
        dn = 0;
        place(); place(); place();
        wait_idle(); tick(); tick();
        chk("t6_done_count", dn, 1);

        // reset while waiting on the occupancy answer
        fill_map(0);
        place();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_occ_req", occ_req, 0);
        chk("t7_food_valid", food_valid, 0);
        chk("t7_food_x", food_x, 0);
        chk("t7_food_y", food_y, 0);
        chk("t7_done", done, 0);
        txn_act = 1'b0;
        exp_fx = 0; exp_fy = 0; exp_fv = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        c0 = cyc;
        set_draw(c0 + 1, 20, 10);
        place();
        wait_until(c0 + 3);
        chk("t7_after_done", done, 1);
        chk("t7_after_food_x", food_x, 20);
        chk("t7_after_food_y", food_y, 10);
        wait_idle(); tick();

        // randomized placements over varied occupancy
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       fill_map(0);
                1:       fill_map(30);
                2:       fill_map(75);
                default: fill_map(97);
            endcase
            place();
            if ($urandom_range(0, 1) == 1) begin
                tick();
                place();
            end
            wait_idle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
